// File: rtl/instr_line_buffer.sv
// Instruction line buffer: a ring of 16-bit halfwords that is filled from fetched lines
// and presents up to FETCH_LEN aligned instructions per cycle. Compressed decode is under INSTR_BUF_RVC_EN.
module instr_line_buffer #(
    parameter int BUS_LEN   = 2,
    parameter int BUF_LINES = 4,
    parameter int FETCH_LEN = 2
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             jump_vld,
    input  logic [31:0]                      jump_pc,
    input  logic                             line_vld,
    input  logic [32*BUS_LEN-1:0]            line_data,
    output logic                             buffer_free,
    output logic [FETCH_LEN-1:0]             instr_vld,
    output logic [32*FETCH_LEN-1:0]          instr_data,
    output logic [32*FETCH_LEN-1:0]          instr_pc,
    input  logic [$clog2(FETCH_LEN+1)-1:0]   instr_acc
);

    localparam int HL = 2 * BUS_LEN;
    localparam int H  = HL * BUF_LINES;
    localparam int PW = $clog2(H);
    localparam int CW = $clog2(H + 1);
    localparam int SW = $clog2(HL);
    localparam int AW = $clog2(FETCH_LEN + 1);
    localparam int OW = $clog2(2 * FETCH_LEN + 1);

    logic [15:0]   ring_q [H];
    logic [PW-1:0] head_q, head_d, tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;
    logic [31:0]   head_pc_q, head_pc_d;
    logic [SW-1:0] skip_q, skip_d;

    logic [OW-1:0] off [FETCH_LEN+1];
    logic [1:0]    sz [FETCH_LEN];
    logic [15:0]   hw_lo [FETCH_LEN];
    logic [15:0]   hw_hi [FETCH_LEN];
    logic          run;
    logic [AW-1:0] n_vld, acc_c;
    logic [OW-1:0] consumed;
    logic [CW-1:0] wr_n, room;
    logic          ovf, do_wr;
    logic [31:0]   jump_pc_adj;
    logic [SW-1:0] skip_j;

    // Walk the ring from head; slot k starts off[k] halfwords past head.
    always_comb begin
        off[0]     = '0;
        run        = 1'b1;
        n_vld      = '0;
        instr_vld  = '0;
        instr_data = '0;
        instr_pc   = '0;
        for (int k = 0; k < FETCH_LEN; k++) begin
            hw_lo[k] = ring_q[head_q + PW'(off[k])];
            hw_hi[k] = ring_q[head_q + PW'(off[k]) + PW'(1)];
`ifdef INSTR_BUF_RVC_EN
            sz[k] = (hw_lo[k][1:0] != 2'b11) ? 2'd1 : 2'd2;
`else
            sz[k] = 2'd2;
`endif
            off[k+1] = off[k] + OW'(sz[k]);
            run = run && (int'(off[k+1]) <= int'(count_q));
            instr_vld[k] = run;
            if (run) begin
                n_vld = AW'(k + 1);
                instr_data[32*k +: 32] = (sz[k] == 2'd1) ? {16'h0000, hw_lo[k]} : {hw_hi[k], hw_lo[k]};
                instr_pc[32*k +: 32]   = head_pc_q + (32'(off[k]) << 1);
            end
        end
    end

    always_comb begin
`ifdef INSTR_BUF_RVC_EN
        jump_pc_adj = jump_pc;
        skip_j      = jump_pc[SW:1];
`else
        jump_pc_adj = {jump_pc[31:2], 2'b00};
        skip_j      = jump_pc[SW:1] & ~SW'(1);
`endif
        acc_c    = (instr_acc > n_vld) ? n_vld : instr_acc;
        consumed = off[acc_c];
        wr_n     = CW'(HL) - CW'(skip_q);
        room     = CW'(H) - count_q;
        ovf      = line_vld && (room < wr_n);
        do_wr    = line_vld && !ovf && !jump_vld;

        head_d    = head_q + PW'(consumed);
        head_pc_d = head_pc_q + (32'(consumed) << 1);
        tail_d    = do_wr ? tail_q + PW'(wr_n) : tail_q;
        count_d   = count_q - CW'(consumed) + (do_wr ? wr_n : '0);
        skip_d    = line_vld ? '0 : skip_q;
        if (jump_vld) begin
            head_d    = '0;
            tail_d    = '0;
            count_d   = '0;
            head_pc_d = jump_pc_adj;
            skip_d    = skip_j;
        end
    end

    // Slack of one extra line covers a fetch already in flight when this drops.
    assign buffer_free = (CW'(H) - count_q) >= CW'(2 * HL);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head_q    <= '0;
            tail_q    <= '0;
            count_q   <= '0;
            head_pc_q <= '0;
            skip_q    <= '0;
        end else begin
            head_q    <= head_d;
            tail_q    <= tail_d;
            count_q   <= count_d;
            head_pc_q <= head_pc_d;
            skip_q    <= skip_d;
        end
    end

    // Storage is not reset: nothing is visible until count covers it.
    always_ff @(posedge clk) begin
        if (do_wr) begin
            for (int i = 0; i < HL; i++) begin
                if (i >= int'(skip_q))
                    ring_q[tail_q + PW'(i) - PW'(skip_q)] <= line_data[16*i +: 16];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst && line_vld && !jump_vld)
            assert (!ovf) else $error("instr_line_buffer: line written with insufficient room, dropped");
    end

endmodule

// File: doc/instr_line_buffer.md
Name: instr_line_buffer

Overview:
- Sits directly downstream of the fetch controller.
- Accepts fetched instruction lines and the jump redirect, and stores the stream as 16-bit halfwords in a ring buffer.
- Extracts up to FETCH_LEN aligned instructions per cycle (RVC-aware) with their PCs for the decoder.
- Drives buffer_free back to the fetch controller as flow control.

Parameters:
- BUS_LEN, 2: 32-bit words per fetched line; a line is 32*BUS_LEN bits = 2*BUS_LEN halfwords (HL).
- BUF_LINES, 4: capacity in lines; total capacity H = HL*BUF_LINES halfwords; must be a power of two.
- FETCH_LEN, 2: maximum instructions presented per cycle.

Ports:
- clk  input  1  clock
- rst  input  1  asynchronous reset, active-low
- jump_vld  input  1  redirect; flush buffer, restart at jump_pc
- jump_pc  input  32  redirect target, bit 0 always 0
- line_vld  input  1  fetched line valid this cycle
- line_data  input  32*BUS_LEN  fetched line, halfword 0 at bits [15:0]
- buffer_free  output  1  room for two more lines
- instr_vld  output  FETCH_LEN  thermometer valid, bit k = slot k
- instr_data  output  32*FETCH_LEN  slot k at [32k+31:32k]; 16-bit instructions zero-extended
- instr_pc  output  32*FETCH_LEN  PC of slot k
- instr_acc  input  $clog2(FETCH_LEN+1)  number of slots consumed this cycle

Behaviour:
- State:
  - Ring of H halfwords; head/tail pointers modulo H.
  - count of valid halfwords, 0..H.
  - head_pc (32b).
  - skip field: number of halfwords to discard from the next line.
- Reset (rst=0):
  - count=0, head/tail=0, head_pc=0, skip=0.
  - Outputs: instr_vld=0, instr_data=0, instr_pc=0, buffer_free=1.
- Jump (highest priority):
  - Next cycle: count=0, head=tail=0, head_pc=jump_pc.
  - skip = jump_pc[$clog2(HL)+0:1], i.e. the halfword offset of jump_pc within its line.
  - A line_vld in the same cycle is dropped; instr_acc in the same cycle is ignored.
- Line write:
  - On line_vld without jump, append halfwords skip..HL-1 at tail, wrapping modulo H.
  - count += HL-skip; skip clears to 0.
  - Latency: data visible on instr_* the cycle after line_vld.
- Slot extraction (combinational from registered state):
  - Walk from head; a halfword with [1:0]!=2'b11 is a 16-bit instruction, otherwise 32-bit.
  - Slot k is valid only if all its halfwords are present (cumulative size <= count).
  - instr_vld is strictly thermometer.
  - instr_pc[k] = head_pc + 2*(halfwords before slot k).
  - Invalid slots drive data=0 and pc=0.
- Consume:
  - instr_acc larger than the number of valid slots is clamped to that number.
  - Removed halfwords = sum of sizes of the first instr_acc slots; head and head_pc advance accordingly.
  - Write and consume in the same cycle are legal: count_next = count + written - consumed.
- buffer_free = (H - count) >= 2*HL, from registered count. The slack covers one line already in flight.
- Overflow:
  - line_vld arriving with H-count < HL-skip is a protocol violation.
  - The line is dropped; no state changes except skip.
  - A simulation-only $error is issued.
- Wrap: pointers wrap silently modulo H; a 32-bit instruction may straddle the wrap point and is reassembled correctly.

Optional Feature:
- Macro INSTR_BUF_RVC_EN.
- Defined:
  - Compressed decoding as above.
  - jump_pc[1] contributes to skip.
- Undefined:
  - Every slot is 32-bit (2 halfwords) regardless of encoding.
  - jump_pc[1] is ignored, so skip is even.
  - A halfword-size decode is not generated.

Test Plan (BUS_LEN=2, FETCH_LEN=2, BUF_LINES=4, H=16):
1. Reset, jump 0x200, line 0x00000013_00000013 -> next cycle instr_vld=2'b11, pc 0x200/0x204, data 0x13/0x13; buffer_free=1 throughout.
2. Jump 0x206, line with hw3=0x0093 -> instr_vld=0; following line with hw0=0x00A0 -> instr_vld[0]=1, pc 0x206, data 0x00A00093.
3. RVC (macro on), line hw0..3 = 0x4505,0x0513,0x0000,0x0001 -> slot0 pc 0x200 data 0x00004505; slot1 pc 0x202 data 0x00000513. After instr_acc=2: slot0 pc 0x206 data 0x00000001, instr_vld=2'b01.
4. Three NOP lines at 0x200, instr_acc=0 -> count=12, buffer_free=0; then instr_acc=2 -> count=8, buffer_free=1 the next cycle.
5. Jump 0x300 coinciding with line_vld and instr_acc=2 -> line dropped, instr_vld=0 next cycle; the next line yields slot0 pc 0x300.
6. Ten consecutive NOP lines from 0x200, instr_acc=2 every valid cycle -> PCs 0x200..0x24C contiguous across pointer wrap; no drop; no $error.
